flexka_mul_pipe: RTL
====================

Name: flexka_mul_pipe

Overview:
- Parametrised successor to the fixed-latency multiplier: a W x W -> 2W multiplier with a configurable pipeline depth and a valid/ready handshake on both sides.
- Carries a per-operation tag so results can be matched to requests.
- Whole-pipeline stall under output backpressure; no result is ever dropped or duplicated.
- Sits between the FlexKA operand schedulers and the accumulate/reduce logic wherever backpressure can occur.

Parameters:
- W, default FSIZE: operand width in bits; product width is 2*W.
- LATENCY, default MULTIPLIER_LATENCY: pipeline stages from input acceptance to output valid; must be >= 1.
- TAG_W, default 8: width of the opaque tag carried alongside each operation.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair and tag are valid.
- in_ready  output  1  block accepts an operation this cycle.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_signed  input  1  1 = treat A and B as two's complement; 0 = unsigned.
- in_tag  input  TAG_W  opaque tag returned with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_p  output  2*W  product.
- out_tag  output  TAG_W  tag of this result.
- busy  output  1  at least one operation is in flight.

Behaviour:
- Pipeline: LATENCY stage registers, each holding a valid bit, partial/final product and tag. Stage 0 captures the input; stage LATENCY-1 drives the outputs.
- Advance condition: adv = !v[LATENCY-1] || out_ready.
  - in_ready = adv, combinational; it must not depend on in_valid.
  - When adv is high, every stage shifts by one: v[0] <= in_valid, and v[i] <= v[i-1].
  - When adv is low, all stages hold their contents and outputs are stable.
- Accept = in_valid && in_ready. Transfer = out_valid && out_ready.
- Latency: with out_ready held high, an operation accepted at cycle t gives out_valid at cycle t+LATENCY.
- Throughput: one operation per cycle with out_ready high. Bubbles are not collapsed; a bubble in the pipeline still travels to the output.
- out_valid = v[LATENCY-1]. out_p and out_tag are stable while out_valid && !out_ready.
- busy = OR of all v[i].
- Arithmetic:
  - Unsigned mode: out_p = zero-extended A * B, full 2W bits.
  - Signed mode: out_p = two's complement product of sign-extended A and B, truncated to 2W bits. The truncation is exact, since the result always fits in 2W bits.
  - in_signed is captured with its operation; it may change every cycle.
- Product computation point is implementation choice: compute in stage 0, or split across stages. The result must be bit-exact with the rules above.
- Data registers of invalid stages may hold stale values; out_p and out_tag are don't-care while out_valid is 0.
- Reset:
  - On RST, all v[i] <= 0, so out_valid = 0 and busy = 0 in the next cycle. in_ready is then 1.
  - Reset mid-operation discards all in-flight operations with no output.
  - Reset dominates a simultaneous accept.
  - Data and tag registers need no reset.
- Out of scope: no error or overflow flags.

Optional Feature:
- Macro FLEXKA_MUL_SIGNED_EN.
- Defined: signed mode is honoured exactly as described in Behaviour.
- Undefined: in_signed is ignored, every operation is unsigned, and no sign-extension logic is synthesised. Port list is unchanged.

Decomposition:
- FLEXKA_PKG additions:
  - FSIZE and MULTIPLIER_LATENCY, as the parameter defaults.
  - MUL_TAG_W.
  - A packed struct mul_req_t {a, b, is_signed, tag} used by the schedulers.
- One sub-module: flexka_mul_stage, holding one valid+payload register with an enable, instantiated LATENCY times via generate.

Test Plan (W=16, LATENCY=3, TAG_W=8):
- Unsigned streaming: A=0xFFFF, B=0xFFFF, tag=0x11, out_ready=1 -> at t+3: out_p=0xFFFE0001, out_tag=0x11, out_valid for exactly 1 cycle.
- Signed: A=0xFFFF(-1), B=0x0002, in_signed=1 -> out_p=0xFFFFFFFE. Same operands with in_signed=0 -> 0x0001FFFE. Without FLEXKA_MUL_SIGNED_EN, both give 0x0001FFFE.
- Back-to-back: 10 ops on consecutive cycles with tags 0..9, out_ready=1 -> 10 consecutive results, tags in order, no gaps.
- Backpressure: 4 ops, out_ready=0 from the first result onward -> in_ready drops once the pipeline is full, outputs hold. Release out_ready -> all 4 results delivered in order, none lost or duplicated.
- Reset mid-flight: 2 ops accepted, RST asserted at t+1 -> no out_valid afterwards, busy=0 and in_ready=1 the cycle after reset.
- Random: 10k random ops with random in_signed, in_valid and out_ready, checked against a reference-model scoreboard -> zero mismatches, order preserved.

Source files
------------

// File: rtl/flexka_mul_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : flexka_mul_pipe_pkg                                           |
// | Purpose  : Shared constants and request type for the FlexKA multiplier.  |
// |            FSIZE / MULTIPLIER_LATENCY / MUL_TAG_W are the parameter      |
// |            defaults of flexka_mul_pipe; mul_req_t is the request bundle  |
// |            built by the operand schedulers.                              |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package flexka_mul_pipe_pkg;

  localparam int FSIZE              = 16;
  localparam int MULTIPLIER_LATENCY = 3;
  localparam int MUL_TAG_W          = 8;

  typedef struct packed {
    logic [FSIZE-1:0]     a;
    logic [FSIZE-1:0]     b;
    logic                 is_signed;
    logic [MUL_TAG_W-1:0] tag;
  } mul_req_t;

  // Width of one pipeline payload word: full product followed by the tag.
  function automatic int mul_payload_w(input int w, input int tag_w);
    return 2 * w + tag_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flexka_mul_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : flexka_mul_stage                                              |
// | Purpose  : One pipeline slot: a valid bit plus an opaque payload word,   |
// |            loaded only when en is high.                                  |
// | Ports    : clk, rst (sync, active-high), en (load strobe),               |
// |            in_valid/in_data (next contents), out_valid/out_data (slot).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module flexka_mul_stage #(
  parameter int PW = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_valid,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  output logic [PW-1:0] out_data
);

  // Only the valid bit is reset; stale payload behind a cleared valid is
  // never observed downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      out_data <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/flexka_mul_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : flexka_mul_pipe                                               |
// | Purpose  : W x W -> 2W multiplier with LATENCY pipeline slots, a tag     |
// |            carried with each operation and valid/ready on both sides.    |
// |            The whole pipe stalls under output backpressure.              |
// | Ports    : CLK, RST (sync, active-high)                                  |
// |            in_valid/in_ready, in_a, in_b, in_signed, in_tag  (request)   |
// |            out_valid/out_ready, out_p, out_tag               (result)    |
// |            busy - at least one operation in flight                       |
// | Config   : FLEXKA_MUL_SIGNED_EN - when defined, in_signed selects        |
// |            two's complement operands; otherwise every op is unsigned     |
// |            and in_signed is ignored.                                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module flexka_mul_pipe
  import flexka_mul_pipe_pkg::*;
#(
  parameter int W       = FSIZE,
  parameter int LATENCY = MULTIPLIER_LATENCY,  // must be >= 1
  parameter int TAG_W   = MUL_TAG_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PW = mul_payload_w(W, TAG_W);

  logic [LATENCY-1:0] w_v;
  logic [PW-1:0]      w_pay [LATENCY];
  logic               w_adv;
  logic [2*W-1:0]     w_prod;

  // Single advance strobe for every slot: the pipe only moves when the last
  // slot is empty or being drained, so nothing is overwritten or repeated.
  assign w_adv    = !w_v[LATENCY-1] || out_ready;
  assign in_ready = w_adv;

  // Full product is formed before stage 0; later stages just carry it.
`ifdef FLEXKA_MUL_SIGNED_EN
  logic [2*W-1:0] w_a_ext;
  logic [2*W-1:0] w_b_ext;

  // Multiplying the 2W-bit sign extensions and keeping the low 2W bits
  // yields the exact two's complement product.
  assign w_a_ext = {{W{in_signed & in_a[W-1]}}, in_a};
  assign w_b_ext = {{W{in_signed & in_b[W-1]}}, in_b};
  assign w_prod  = w_a_ext * w_b_ext;
`else
  logic w_unused_signed;

  assign w_unused_signed = in_signed;
  assign w_prod          = {{W{1'b0}}, in_a} * {{W{1'b0}}, in_b};
`endif

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    if (i == 0) begin : g_head
      flexka_mul_stage #(
        .PW (PW)
      ) u_stage (
        .clk       (CLK),
        .rst       (RST),
        .en        (w_adv),
        .in_valid  (in_valid),
        .in_data   ({w_prod, in_tag}),
        .out_valid (w_v[i]),
        .out_data  (w_pay[i])
      );
    end else begin : g_body
      flexka_mul_stage #(
        .PW (PW)
      ) u_stage (
        .clk       (CLK),
        .rst       (RST),
        .en        (w_adv),
        .in_valid  (w_v[i-1]),
        .in_data   (w_pay[i-1]),
        .out_valid (w_v[i]),
        .out_data  (w_pay[i])
      );
    end
  end

  assign out_valid = w_v[LATENCY-1];
  assign out_p     = w_pay[LATENCY-1][PW-1:TAG_W];
  assign out_tag   = w_pay[LATENCY-1][TAG_W-1:0];
  assign busy      = |w_v;

endmodule
`default_nettype wire
